alu_response_monitor: RTL and testbench

Response analyzer that sits on the ALU output side of the MIPS-PPU datapath and consumes the ALU's result (`y`), flags (`{N,Z}`) and the opcode that produced them. Over a programmed run of `N_TXN` accepted samples it compacts every response into a 32-bit MISR signature and keeps saturating counts of Z and N flags. It is the capture end of the ALU self-test path, so a full opcode sweep resolves to one signature compared against a golden value. It is purely sequential observation logic and never drives the ALU.

---
 rtl/alu_response_monitor_if.sv | 28 ++
 rtl/alu_response_monitor.sv | 89 ++++++++
 tb/tb_alu_response_monitor.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/alu_response_monitor_if.sv
// Bundle of ALU response-side signals observed by alu_response_monitor.
//   master: drives the ALU response (start, in_valid, opcode, y, flags) and reads status.
//   slave : the monitor; reads the response and drives handshake, status and results.
interface alu_response_monitor_if;
  logic        start;
  logic        in_valid;
  logic [3:0]  opcode;
  logic [31:0] y;
  logic [1:0]  flags;         // [0]=Z, [1]=N
  logic        in_ready;
  logic        busy;
  logic        done;
  logic [31:0] signature;
  logic [7:0]  txn_count;
  logic [7:0]  zero_count;
  logic [7:0]  neg_count;
  logic        illegal_seen;

  modport master (
    output start, in_valid, opcode, y, flags,
    input  in_ready, busy, done, signature, txn_count, zero_count, neg_count, illegal_seen
  );

  modport slave (
    input  start, in_valid, opcode, y, flags,
    output in_ready, busy, done, signature, txn_count, zero_count, neg_count, illegal_seen
  );
endinterface

// File: rtl/alu_response_monitor.sv
// ALU response analyzer: over a run of N_TXN accepted samples it compacts each
// {opcode, y, flags} response into a 32-bit MISR signature and keeps saturating
// Z/N flag counts plus a sticky illegal-opcode flag. Pure observation logic.
// Ports:
//   clk   - single clock, rising edge
//   rst_n - asynchronous active-low reset
//   mon   - alu_response_monitor_if.slave (response inputs, handshake and results)
module alu_response_monitor #(
  parameter int unsigned N_TXN = 13,
  parameter logic [31:0] SEED  = 32'h0000_0000,
  parameter logic [31:0] POLY  = 32'h0040_0007
) (
  input  logic                        clk,
  input  logic                        rst_n,
  alu_response_monitor_if.slave       mon
);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  localparam logic [7:0] LastTxn = 8'(N_TXN);
  localparam logic [3:0] MaxOpcode = 4'd12;

  state_e      state_q, state_d;
  logic [31:0] sig_q, sig_d;
  logic [7:0]  txn_q, txn_d;
  logic [7:0]  zero_q, zero_d;
  logic [7:0]  neg_q, neg_d;
  logic        ill_q, ill_d;

  logic        accept;
  logic [31:0] data_word;

  // start takes priority over a sample presented in the same cycle.
  assign accept    = mon.in_valid && (state_q == StRun) && !mon.start;
  assign data_word = mon.y ^ {mon.opcode, 26'b0, mon.flags};

  always_comb begin
    state_d = state_q;
    sig_d   = sig_q;
    txn_d   = txn_q;
    zero_d  = zero_q;
    neg_d   = neg_q;
    ill_d   = ill_q;

    if (mon.start) begin
      state_d = StRun;
      sig_d   = SEED;
      txn_d   = 8'd0;
      zero_d  = 8'd0;
      neg_d   = 8'd0;
      ill_d   = 1'b0;
    end else if (accept) begin
      sig_d = {sig_q[30:0], 1'b0} ^ (sig_q[31] ? POLY : 32'h0) ^ data_word;
      txn_d = txn_q + 8'd1;
      if (mon.flags[0] && (zero_q != 8'hFF)) zero_d = zero_q + 8'd1;
      if (mon.flags[1] && (neg_q != 8'hFF))  neg_d  = neg_q + 8'd1;
      if (mon.opcode > MaxOpcode) ill_d = 1'b1;
      if (txn_d == LastTxn) state_d = StDone;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      sig_q   <= 32'h0;
      txn_q   <= 8'd0;
      zero_q  <= 8'd0;
      neg_q   <= 8'd0;
      ill_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sig_q   <= sig_d;
      txn_q   <= txn_d;
      zero_q  <= zero_d;
      neg_q   <= neg_d;
      ill_q   <= ill_d;
    end
  end

  assign mon.in_ready     = (state_q == StRun);
  assign mon.busy         = (state_q == StRun);
  assign mon.done         = (state_q == StDone);
  assign mon.signature    = sig_q;
  assign mon.txn_count    = txn_q;
  assign mon.zero_count   = zero_q;
  assign mon.neg_count    = neg_q;
  assign mon.illegal_seen = ill_q;

endmodule

// File: tb/tb_alu_response_monitor.sv
// Bench for alu_response_monitor: four instances with different N_TXN/SEED share
// one stimulus stream; each is compared every cycle against a sample-list model.
module tb_alu_response_monitor;

  localparam int NI = 4;
  localparam int unsigned NT [NI] = '{13, 1, 2, 1};
  localparam logic [31:0] SD [NI] = '{32'h0, 32'h0, 32'h0, 32'h8000_0000};
  localparam logic [31:0] POLY = 32'h0040_0007;

  logic clk = 1'b0;
  logic rst_n;
  logic start, in_valid;
  logic [3:0] opcode;
  logic [31:0] y;
  logic [1:0] flags;

  logic [31:0] o_sig [NI];
  logic [7:0]  o_txn [NI], o_zero [NI], o_neg [NI];
  logic        o_ill [NI], o_rdy [NI], o_busy [NI], o_done [NI];

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    alu_response_monitor_if ifc ();
    assign ifc.start    = start;
    assign ifc.in_valid = in_valid;
    assign ifc.opcode   = opcode;
    assign ifc.y        = y;
    assign ifc.flags    = flags;
    alu_response_monitor #(
      .N_TXN(NT[g]),
      .SEED (SD[g]),
      .POLY (POLY)
    ) u_dut (
      .clk  (clk),
      .rst_n(rst_n),
      .mon  (ifc)
    );
    assign o_sig[g]  = ifc.signature;
    assign o_txn[g]  = ifc.txn_count;
    assign o_zero[g] = ifc.zero_count;
    assign o_neg[g]  = ifc.neg_count;
    assign o_ill[g]  = ifc.illegal_seen;
    assign o_rdy[g]  = ifc.in_ready;
    assign o_busy[g] = ifc.busy;
    assign o_done[g] = ifc.done;
  end

  // Model: run/done flags plus the list of data words accepted this run.
  bit          m_started [NI];
  bit          m_run [NI];
  bit          m_done [NI];
  int          m_cnt [NI];
  int          m_z [NI];
  int          m_n [NI];
  bit          m_ill [NI];
  logic [31:0] m_w [NI][256];

  int n_checks = 0;
  int n_err = 0;

  function automatic logic [31:0] exp_sig(int i);
    logic [31:0] s;
    s = m_started[i] ? SD[i] : 32'h0;
    for (int k = 0; k < m_cnt[i]; k++)
      s = {s[30:0], 1'b0} ^ (s[31] ? POLY : 32'h0) ^ m_w[i][k];
    return s;
  endfunction

  function automatic int sat(int v);
    return (v > 255) ? 255 : v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NI; i++) begin
      m_started[i] = 0; m_run[i] = 0; m_done[i] = 0;
      m_cnt[i] = 0; m_z[i] = 0; m_n[i] = 0; m_ill[i] = 0;
    end
  endtask

  task automatic model_edge();
    if (!rst_n) begin
      model_reset();
      return;
    end
    for (int i = 0; i < NI; i++) begin
      if (start) begin
        m_started[i] = 1; m_run[i] = 1; m_done[i] = 0;
        m_cnt[i] = 0; m_z[i] = 0; m_n[i] = 0; m_ill[i] = 0;
      end else if (m_run[i] && in_valid) begin
        m_w[i][m_cnt[i]] = y ^ ({28'h0, opcode} << 28) ^ {30'h0, flags};
        m_cnt[i]++;
        if (flags[0]) m_z[i]++;
        if (flags[1]) m_n[i]++;
        if (opcode > 12) m_ill[i] = 1;
        if (m_cnt[i] == int'(NT[i])) begin
          m_run[i] = 0; m_done[i] = 1;
        end
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  task automatic check_all();
    for (int i = 0; i < NI; i++) begin
      chk($sformatf("u%0d signature", i), o_sig[i], exp_sig(i));
      chk($sformatf("u%0d txn_count", i), {24'h0, o_txn[i]}, 32'(m_cnt[i]));
      chk($sformatf("u%0d zero_count", i), {24'h0, o_zero[i]}, 32'(sat(m_z[i])));
      chk($sformatf("u%0d neg_count", i), {24'h0, o_neg[i]}, 32'(sat(m_n[i])));
      chk($sformatf("u%0d illegal_seen", i), {31'h0, o_ill[i]}, {31'h0, m_ill[i]});
      chk($sformatf("u%0d in_ready", i), {31'h0, o_rdy[i]}, {31'h0, m_run[i]});
      chk($sformatf("u%0d busy", i), {31'h0, o_busy[i]}, {31'h0, m_run[i]});
      chk($sformatf("u%0d done", i), {31'h0, o_done[i]}, {31'h0, m_done[i]});
    end
  endtask

  // Drive one cycle of stimulus, advance the model over the edge, then check.
  task automatic cyc(input logic st, input logic v, input logic [3:0] op,
                     input logic [31:0] yy, input logic [1:0] fl);
    start = st; in_valid = v; opcode = op; y = yy; flags = fl;
    model_edge();
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic idle_cyc();
    cyc(1'b0, 1'b0, 4'h0, 32'h0, 2'b00);
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0; in_valid = 1'b0; opcode = 4'h0; y = 32'h0; flags = 2'b00;
    model_reset();
    #12;
    check_all();
    rst_n = 1'b1;

    // in_valid in IDLE is ignored
    cyc(1'b0, 1'b1, 4'h3, 32'hDEAD_BEEF, 2'b11);

    // Directed known-answer sequence
    cyc(1'b1, 1'b0, 4'h0, 32'h0, 2'b00);
    cyc(1'b0, 1'b1, 4'h0, 32'h1, 2'b00);
    chk("n1 sig after y=1", o_sig[1], 32'h0000_0001);
    chk("n1 done", {31'h0, o_done[1]}, 32'h1);
    chk("n1 txn", {24'h0, o_txn[1]}, 32'h1);
    cyc(1'b0, 1'b1, 4'h0, 32'h1, 2'b00);
    chk("n2 sig two y=1", o_sig[2], 32'h0000_0003);
    chk("n2 done", {31'h0, o_done[2]}, 32'h1);
    chk("n1 frozen in DONE", o_sig[1], 32'h0000_0001);

    cyc(1'b1, 1'b0, 4'h0, 32'h0, 2'b00);
    cyc(1'b0, 1'b1, 4'h2, 32'h0, 2'b01);
    chk("n2 sig op2 z", o_sig[2], 32'h2000_0001);
    chk("n2 zero_count", {24'h0, o_zero[2]}, 32'h1);
    chk("seed8 sig op2 z", o_sig[3], 32'h2040_0006);

    cyc(1'b1, 1'b0, 4'h0, 32'h0, 2'b00);
    cyc(1'b0, 1'b1, 4'h0, 32'h0, 2'b00);
    chk("seed8 feedback", o_sig[3], 32'h0040_0007);

    // Full 13-opcode sweep with a gap after every other sample
    cyc(1'b1, 1'b0, 4'h0, 32'h0, 2'b00);
    for (int k = 0; k < 13; k++) begin
      cyc(1'b0, 1'b1, 4'(k), $urandom, 2'($urandom_range(0, 3)));
      if (k % 2 == 0) cyc(1'b0, 1'b0, 4'hF, $urandom, 2'b11);
    end
    chk("sweep txn_count", {24'h0, o_txn[0]}, 32'd13);
    chk("sweep done", {31'h0, o_done[0]}, 32'h1);
    chk("sweep no illegal", {31'h0, o_ill[0]}, 32'h0);

    // in_valid in DONE is ignored
    for (int k = 0; k < 3; k++) cyc(1'b0, 1'b1, 4'($urandom), $urandom, 2'b11);

    // Illegal opcode run
    cyc(1'b1, 1'b0, 4'h0, 32'h0, 2'b00);
    cyc(1'b0, 1'b1, 4'hD, 32'h1234_5678, 2'b10);
    chk("illegal_seen", {31'h0, o_ill[0]}, 32'h1);

    // start in RUN with in_valid: sample dropped
    cyc(1'b1, 1'b1, 4'h1, 32'hFFFF_0000, 2'b11);
    chk("restart txn 0", {24'h0, o_txn[0]}, 32'h0);
    chk("restart sig seed", o_sig[3], 32'h8000_0000);
    chk("restart illegal cleared", {31'h0, o_ill[0]}, 32'h0);

    // Asynchronous reset mid-run
    cyc(1'b0, 1'b1, 4'h5, 32'hA5A5_A5A5, 2'b01);
    cyc(1'b0, 1'b1, 4'h6, 32'h5A5A_5A5A, 2'b10);
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    chk("async in_ready low", {31'h0, o_rdy[0]}, 32'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    check_all();

    // Randomized traffic
    for (int k = 0; k < 400; k++) begin
      cyc(1'($urandom_range(0, 19) == 0), 1'($urandom_range(0, 3) != 0),
          4'($urandom), $urandom, 2'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
